chirp_ftw_sweep: RTL and testbench
==================================

# chirp_ftw_sweep

Linear-chirp sweep controller that drives the frequency tuning word (FTW) input of the chirp phase accumulator. On a start pulse it latches a sweep description and emits one FTW per clock, ramping from `ftw_start` toward `ftw_stop` in steps of `ftw_step`. It can repeat the sweep a programmed number of times, with an optional idle gap between sweeps. It sits between the register/control logic and the phase accumulator, and also provides sweep-sync and done indications to downstream capture logic.

## Interface
- `N`, 32, FTW width; must equal the phase accumulator width.
- `CW`, 16, width of the gap and sweep-count fields.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `abort`  in  1  synchronous stop; ends the operation on the next edge.
- `ftw_start`  in  N  first FTW of each sweep (unsigned).
- `ftw_step`  in  N  per-cycle FTW increment (unsigned).
- `ftw_stop`  in  N  upper FTW bound, inclusive.
- `gap_len`  in  CW  number of idle cycles between sweeps.
- `n_sweeps`  in  CW  number of sweeps; 0 is treated as 1.
- `ftw`  out  N  tuning word to the accumulator; 0 whenever `ftw_valid`=0.
- `ftw_valid`  out  1  high while a sweep sample is on `ftw`.
- `sweep_sync`  out  1  1-cycle pulse coincident with the first sample of each sweep.
- `busy`  out  1  high in SWEEP and GAP.
- `done`  out  1  1-cycle pulse after the last sample of the last sweep.

## Operation
- Registers: state, `ftw`, latched start/step/stop/gap/count, gap counter, sweep counter.
- On `start` in IDLE, all five inputs are latched. Input changes during an operation have no effect.
- States:
  - IDLE: waits for `start`.
  - SWEEP: emits samples.
  - GAP: counts idle cycles.
  - DONE is not a state. `done` is a registered pulse generated on the SWEEP→IDLE transition.
- IDLE → SWEEP on `start`. The first sample is `ftw_start`, with `sweep_sync`=1.
- Each SWEEP cycle computes `nxt` = `ftw` + step at N+1 bits.
  - If `nxt` > stop, or bit N of `nxt` is set (overflow), the current sample is the last sample of the sweep.
  - Otherwise the next sample is `nxt[N-1:0]`.
  - No wrap-around is ever emitted.
- Samples per sweep = floor((stop−start)/step)+1.
- Degenerate sweep descriptions produce exactly one sample, `ftw_start`:
  - step = 0;
  - start > stop.
- After the last sample of a sweep:
  - If sweeps remain and gap > 0: go to GAP for exactly `gap_len` cycles with `ftw_valid`=0, then SWEEP restarts at `ftw_start` with `sweep_sync`.
  - If sweeps remain and gap = 0: the next cycle is directly `ftw_start` with `sweep_sync`. There is no bubble.
  - If this was the final sweep: go to IDLE. `done`=1 for one cycle and `busy`=0 in that same cycle.
- `abort` (any state): the next cycle is IDLE with all outputs 0. No `done` pulse.
- `abort` takes priority over `start` in the same cycle.
- `start` while `busy` is ignored; it is not queued.
- Reset, including mid-sweep: state=IDLE, and `ftw`, `ftw_valid`, `sweep_sync`, `busy`, `done` are all 0.

## Timing
- Latency: `start` is sampled at edge k. The first sample, `busy`, and `sweep_sync` are valid after edge k+1.
- One sample per clock during SWEEP, with no stalls.
- `done` is high in the cycle after the final sample. A new `start` is accepted in that same cycle, giving the first sample 1 cycle later.
- All outputs are registered; there are no combinational input-to-output paths.
- `ftw` = 0 outside SWEEP, so the accumulator phase holds between sweeps.

## Test plan
- Basic sweep: start=100, step=10, stop=130, n=1, gap=0.
  - `ftw` = 100, 110, 120, 130 on 4 consecutive cycles, with `sweep_sync` on the 100 sample.
  - `done` in the next cycle; `busy` high for exactly 4 cycles.
- Non-aligned stop and degenerate descriptions:
  - stop=135 (otherwise as the basic sweep) → the same 4 samples; 140 is never emitted.
  - step=0 → one sample of 100, then `done`.
  - start=200, stop=100 → one sample of 200, then `done`.
- Overflow: start=0xFFFF_FFF0, step=0x10, stop=0xFFFF_FFFF → a single sample 0xFFFF_FFF0, then `done`. No 0x0 sample.
- Repeat with gap: start=0, step=1, stop=2, n=2, gap=3.
  - Output sequence: 0, 1, 2, three invalid cycles, 0, 1, 2, then `done`.
  - Two `sweep_sync` pulses; `busy` continuous for 9 cycles.
  - The same setup with gap=0 gives 0, 1, 2, 0, 1, 2 back-to-back.
- Control edge cases:
  - `start` pulsed mid-sweep → ignored, and the sequence is unchanged.
  - `abort` on the third sample → next cycle all outputs 0, no `done`.
  - `rst` asserted mid-GAP → all outputs 0 immediately.
  - After `rst` release, a new `start` runs normally.

Source files
------------

// File: rtl/chirp_ftw_sweep_if.sv
// Sweep control/config bundle between the register block (master) and the
// chirp sweep controller (slave).
interface chirp_ftw_sweep_if #(
    parameter int N  = 32,
    parameter int CW = 16
);
    logic          start;
    logic          abort;
    logic [N-1:0]  ftw_start;
    logic [N-1:0]  ftw_step;
    logic [N-1:0]  ftw_stop;
    logic [CW-1:0] gap_len;
    logic [CW-1:0] n_sweeps;
    logic [N-1:0]  ftw;
    logic          ftw_valid;
    logic          sweep_sync;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, ftw_start, ftw_step, ftw_stop, gap_len, n_sweeps,
        input  ftw, ftw_valid, sweep_sync, busy, done
    );

    modport slave (
        input  start, abort, ftw_start, ftw_step, ftw_stop, gap_len, n_sweeps,
        output ftw, ftw_valid, sweep_sync, busy, done
    );
endinterface

// File: rtl/chirp_ftw_sweep.sv
// Linear-chirp FTW sweep controller: ramps the tuning word from start toward
// stop, repeating with an optional idle gap, with sync and done strobes.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | waiting for start, ftw held at 0
//   S_SWEEP | one sample per clock on ftw
//   S_GAP   | idle cycles between sweeps, gap_cnt_q counts down
module chirp_ftw_sweep #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    chirp_ftw_sweep_if.slave    ctrl_if
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  ftw_q, ftw_d;
    logic [N-1:0]  start_q, start_d;
    logic [N-1:0]  step_q, step_d;
    logic [N-1:0]  stop_q, stop_d;
    logic [CW-1:0] gap_q, gap_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [CW-1:0] sweep_rem_q, sweep_rem_d;
    logic          sync_q, sync_d;
    logic          done_q, done_d;

    logic [N:0]    nxt;
    logic          last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ftw_q       <= '0;
            start_q     <= '0;
            step_q      <= '0;
            stop_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            sweep_rem_q <= '0;
            sync_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ftw_q       <= ftw_d;
            start_q     <= start_d;
            step_q      <= step_d;
            stop_q      <= stop_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            sweep_rem_q <= sweep_rem_d;
            sync_q      <= sync_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ftw_d       = ftw_q;
        start_d     = start_q;
        step_d      = step_q;
        stop_d      = stop_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        sweep_rem_d = sweep_rem_q;
        sync_d      = 1'b0;
        done_d      = 1'b0;
        // Extra bit catches overflow so a wrapped word is never emitted; a zero
        // step would otherwise never terminate.
        nxt  = {1'b0, ftw_q} + {1'b0, step_q};
        last = (nxt > {1'b0, stop_q}) || (step_q == '0);

        case (state_q)
            S_IDLE: begin
                if (ctrl_if.start) begin
                    state_d     = S_SWEEP;
                    ftw_d       = ctrl_if.ftw_start;
                    start_d     = ctrl_if.ftw_start;
                    step_d      = ctrl_if.ftw_step;
                    stop_d      = ctrl_if.ftw_stop;
                    gap_d       = ctrl_if.gap_len;
                    sweep_rem_d = (ctrl_if.n_sweeps == '0) ? '0
                                                           : ctrl_if.n_sweeps - CW'(1);
                    sync_d      = 1'b1;
                end
            end
            S_SWEEP: begin
                if (!last) begin
                    ftw_d = nxt[N-1:0];
                end else if (sweep_rem_q != '0) begin
                    sweep_rem_d = sweep_rem_q - CW'(1);
                    if (gap_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q;
                        ftw_d     = '0;
                    end else begin
                        ftw_d  = start_q;
                        sync_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    ftw_d   = '0;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == CW'(1)) begin
                    state_d = S_SWEEP;
                    ftw_d   = start_q;
                    sync_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ftw_d   = '0;
            end
        endcase

        if (ctrl_if.abort) begin
            state_d = S_IDLE;
            ftw_d   = '0;
            sync_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        ctrl_if.ftw        = ftw_q;
        ctrl_if.ftw_valid  = (state_q == S_SWEEP);
        ctrl_if.sweep_sync = sync_q;
        ctrl_if.busy       = (state_q != S_IDLE);
        ctrl_if.done       = done_q;
    end
endmodule

// File: tb/tb_chirp_ftw_sweep.sv
// Self-checking bench for chirp_ftw_sweep: directed plan cases plus random
// sweeps compared against a per-cycle expected-output list.
module tb_chirp_ftw_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chirp_ftw_sweep_if #(.N(32), .CW(16)) sw_if ();

    chirp_ftw_sweep #(.N(32), .CW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (sw_if)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] f;
        logic        s;
        logic        b;
        logic        d;
    } smp_t;

    smp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   op_idx = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL op%0d %s: got %0h, want %0h", op_idx, tag, obs, exp_v);
    endtask

    task automatic check_out(input smp_t e, input string where);
        check_eq({where, ".valid"}, 64'(sw_if.ftw_valid),  64'(e.v));
        check_eq({where, ".ftw"},   64'(sw_if.ftw),        64'(e.f));
        check_eq({where, ".sync"},  64'(sw_if.sweep_sync), 64'(e.s));
        check_eq({where, ".busy"},  64'(sw_if.busy),       64'(e.b));
        check_eq({where, ".done"},  64'(sw_if.done),       64'(e.d));
    endtask

    // Expected per-cycle outputs from the first sample through the done cycle.
    task automatic build_model(input logic [31:0] st, input logic [31:0] stp,
                               input logic [31:0] sp, input int gap, input int n);
        longint unsigned cnt;
        int nsw;
        exp_q.delete();
        nsw = (n == 0) ? 1 : n;
        if (stp == 0 || st > sp) cnt = 1;
        else cnt = (longint'(sp) - longint'(st)) / longint'(stp) + 1;
        for (int w = 0; w < nsw; w++) begin
            for (longint unsigned j = 0; j < cnt; j++)
                exp_q.push_back('{1'b1, 32'(longint'(st) + j * longint'(stp)), (j == 0), 1'b1, 1'b0});
            if (w < nsw - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back('{1'b0, 32'd0, 1'b0, 1'b1, 1'b0});
        end
        exp_q.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic scramble_inputs();
        sw_if.ftw_start = $urandom;
        sw_if.ftw_step  = $urandom;
        sw_if.ftw_stop  = $urandom;
        sw_if.gap_len   = 16'($urandom);
        sw_if.n_sweeps  = 16'($urandom);
    endtask

    // Entered and left at a falling edge; returns on the done cycle so a
    // following call issues start in that same cycle.
    task automatic run_op(input logic [31:0] st, input logic [31:0] stp, input logic [31:0] sp,
                          input int gap, input int n, input int abort_at,
                          input int mstart_at, input int rst_at);
        smp_t zero;
        zero = '0;
        op_idx++;
        build_model(st, stp, sp, gap, n);
        sw_if.ftw_start = st;
        sw_if.ftw_step  = stp;
        sw_if.ftw_stop  = sp;
        sw_if.gap_len   = 16'(gap);
        sw_if.n_sweeps  = 16'(n);
        sw_if.start     = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            sw_if.start = 1'b0;
            if (i == 0) scramble_inputs();
            check_out(exp_q[i], $sformatf("c%0d", i));
            if (i == mstart_at) begin
                sw_if.start = 1'b1;
                scramble_inputs();
            end
            if (i == abort_at) begin
                sw_if.abort = 1'b1;
                @(negedge clk);
                sw_if.abort = 1'b0;
                check_out(zero, "abort");
                @(negedge clk);
                check_out(zero, "post_abort");
                return;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check_out(zero, "rst_async");
                @(negedge clk);
                check_out(zero, "rst_hold");
                rst = 1'b0;
                @(negedge clk);
                return;
            end
        end
    endtask

    initial begin
        smp_t zero;
        logic [31:0] st, stp, sp;
        int gap, n, ms;
        zero = '0;
        sw_if.start = 1'b0;
        sw_if.abort = 1'b0;
        scramble_inputs();
        repeat (2) @(negedge clk);
        check_out(zero, "reset");
        rst = 1'b0;
        @(negedge clk);
        check_out(zero, "idle");

        run_op(32'd100, 32'd10, 32'd130, 0, 1, -1, -1, -1);
        run_op(32'd100, 32'd10, 32'd135, 0, 1, -1, -1, -1);
        run_op(32'd100, 32'd0,  32'd130, 0, 1, -1, -1, -1);
        run_op(32'd200, 32'd10, 32'd100, 0, 1, -1, -1, -1);
        run_op(32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF, 0, 1, -1, -1, -1);
        run_op(32'd0, 32'd1, 32'd2, 3, 2, -1, -1, -1);
        run_op(32'd0, 32'd1, 32'd2, 0, 2, -1, -1, -1);
        run_op(32'd100, 32'd10, 32'd130, 0, 1, -1, 1, -1);
        run_op(32'd100, 32'd10, 32'd130, 0, 1, 2, -1, -1);
        run_op(32'd0, 32'd1, 32'd2, 3, 2, -1, -1, 4);
        run_op(32'd100, 32'd10, 32'd130, 0, 1, -1, -1, -1);
        @(negedge clk);
        check_out(zero, "idle_after");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                st  = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                stp = 32'($urandom_range(0, 64));
                sp  = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            end else begin
                st  = 32'($urandom_range(0, 120));
                stp = 32'($urandom_range(0, 20));
                sp  = 32'($urandom_range(0, 140));
            end
            gap = $urandom_range(0, 3);
            n   = $urandom_range(0, 3);
            build_model(st, stp, sp, gap, n);
            ms = ($urandom_range(0, 1) == 1) ? $urandom_range(0, exp_q.size() - 2) : -1;
            run_op(st, stp, sp, gap, n, -1, ms, -1);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_out(zero, "rnd_idle");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
